id_issue_stage: RTL and testbench
=================================

Name: id_issue_stage

Overview:
Second-generation MIPS32 decode/issue stage. It decodes the instruction and fetches operands through an N-source priority forwarding network. It detects load-use hazards and raises a stall request, and it owns the registered ID/EX pipeline boundary with stall, bubble and flush handling. It sits between the IF/ID register and EX, and talks to the regfile and to the pipeline control block.

Parameters:
DATA_W, 32, operand/register data width
FWD_N, 2, number of forwarding sources (index 0 = youngest = highest priority)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset
pc_i  in  32  PC of instruction in ID
inst_i  in  32  instruction in ID
rf_rdata1_i  in  DATA_W  regfile port 1 data
rf_rdata2_i  in  DATA_W  regfile port 2 data
rf_re1_o  out  1  regfile port 1 read enable (comb)
rf_re2_o  out  1  regfile port 2 read enable (comb)
rf_raddr1_o  out  5  regfile port 1 address (comb)
rf_raddr2_o  out  5  regfile port 2 address (comb)
fwd_we_i  in  FWD_N  per-source write enable
fwd_wa_i  in  5*FWD_N  per-source destination, source k at [5k+4:5k]
fwd_wd_i  in  DATA_W*FWD_N  per-source data
ex_is_load_i  in  1  instruction currently in EX is a load
ex_wd_i  in  5  destination of instruction in EX
id_stall_i  in  1  ctrl: hold ID
ex_stall_i  in  1  ctrl: hold EX
flush_i  in  1  kill ID/EX contents
stall_req_o  out  1  load-use stall request (comb)
ex_aluop_o  out  8  registered ALU op
ex_alusel_o  out  3  registered result select
ex_reg1_o  out  DATA_W  registered operand 1
ex_reg2_o  out  DATA_W  registered operand 2
ex_wd_o  out  5  registered destination
ex_wreg_o  out  1  registered write enable
ex_inst_o  out  32  registered instruction (load offset for EX/MEM)
ex_pc_o  out  32  registered PC
ex_invalid_o  out  1  registered reserved-instruction flag
stall_cnt_o  out  CNT_W  cycles with stall_req_o high, saturating

Behaviour:
- Reset: rst is synchronous, active-high. On reset all registered outputs are 0 (aluop=EXE_NOP_OP, alusel=EXE_RES_NOP) and stall_cnt_o=0.
- Decoded set: AND, OR, XOR, NOR, SLLV, SRLV, SRAV, ADDU, SUBU (SPECIAL, shamt must be 0). SLL, SRL, SRA (SPECIAL, rs must be 0). ANDI, ORI, XORI, LUI, ADDIU, LW. The all-zero word is NOP and is valid. Anything else: invalid=1, no reads, wreg=0.
- Immediate rules: ANDI/ORI/XORI zero-extend. ADDIU/LW sign-extend. LUI imm = {inst[15:0],16'b0}, rs not read. Shifts imm = zero-extended sa.
- Operand rule: a port with re=0 yields imm on that operand. A read of $0 always yields 0 and is never forwarded.
- Forwarding:
  - Scan sources 0..FWD_N-1; the lowest index with we=1 and wa==addr (addr≠0) wins.
  - Otherwise use the regfile data.
  - Each operand port resolves independently.
- Load-use: stall_req_o=1 iff ex_is_load_i and ex_wd_i≠0 and (re1 & raddr1==ex_wd_i or re2 & raddr2==ex_wd_i). It is purely combinational and is not gated by stall inputs.
- ID/EX register update at posedge, in priority order:
  1. rst or flush_i -> bubble (all fields 0).
  2. id_stall_i & !ex_stall_i -> bubble.
  3. id_stall_i & ex_stall_i -> hold.
  4. Otherwise load the decoded values.
  - A bubble has wreg=0 and invalid=0.
- Counter: increments when stall_req_o=1 and rst=0. It holds at all-ones. Flush does not clear it.
- Mid-operation reset clears the counter and ID/EX in the same edge.
- Latency: decode to ex_* is 1 cycle when not stalled.

Test Plan:
- ORI $1,$0,0x1100 then ORI $2,$1,0x0022, source0 forwarding $1=0x1100 -> ex_reg1_o=0x1100, ex_reg2_o=0x22, ex_wd_o=2, ex_wreg_o=1.
- Source0 and source1 both write $3 (0xAAAA/0xBBBB), ADDU $4,$3,$3 -> both operands 0xAAAA. Disable source0 -> 0xBBBB.
- Forward source writes $0=0xFFFF, OR $5,$0,$0 -> operands 0, regfile value ignored.
- ex_is_load_i=1, ex_wd_i=7, inst SLLV $8,$7,$9 -> stall_req_o=1. With id_stall_i=1, ex_stall_i=0, next cycle ex_wreg_o=0 and aluop NOP; stall_cnt_o increments by 1. Case ex_wd_i=0 -> no stall.
- ADDIU $2,$0,0x8000 -> ex_reg2_o=0xFFFF8000. LUI $2,0x1234 -> 0x12340000. Opcode 0x3F -> ex_invalid_o=1, ex_wreg_o=0.
- Hold stall_req high for 2^CNT_W+3 cycles (CNT_W=4) -> counter saturates at 15. Assert flush_i with a valid ADDU -> bubble next cycle. Assert rst -> counter returns to 0.

Source files
------------

// File: rtl/id_issue_stage.sv
// MIPS32 decode/issue stage: decode, forwarded operand fetch,
// load-use stall request and the registered ID/EX boundary.
// Ports: clk/rst (sync, active-high); pc_i/inst_i from IF/ID;
//   rf_* regfile read ports; fwd_* forwarding sources (0 = youngest);
//   ex_is_load_i/ex_wd_i for load-use; id_stall_i/ex_stall_i/flush_i
//   from control; stall_req_o; ex_* registered ID/EX outputs;
//   stall_cnt_o saturating count of stall-request cycles.
module id_issue_stage #(
  parameter int DATA_W = 32,
  parameter int FWD_N  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pc_i,
  input  logic [31:0]             inst_i,
  input  logic [DATA_W-1:0]       rf_rdata1_i,
  input  logic [DATA_W-1:0]       rf_rdata2_i,
  output logic                    rf_re1_o,
  output logic                    rf_re2_o,
  output logic [4:0]              rf_raddr1_o,
  output logic [4:0]              rf_raddr2_o,
  input  logic [FWD_N-1:0]        fwd_we_i,
  input  logic [5*FWD_N-1:0]      fwd_wa_i,
  input  logic [DATA_W*FWD_N-1:0] fwd_wd_i,
  input  logic                    ex_is_load_i,
  input  logic [4:0]              ex_wd_i,
  input  logic                    id_stall_i,
  input  logic                    ex_stall_i,
  input  logic                    flush_i,
  output logic                    stall_req_o,
  output logic [7:0]              ex_aluop_o,
  output logic [2:0]              ex_alusel_o,
  output logic [DATA_W-1:0]       ex_reg1_o,
  output logic [DATA_W-1:0]       ex_reg2_o,
  output logic [4:0]              ex_wd_o,
  output logic                    ex_wreg_o,
  output logic [31:0]             ex_inst_o,
  output logic [31:0]             ex_pc_o,
  output logic                    ex_invalid_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLLV  = 8'h04;
  localparam logic [7:0] OP_SRLV  = 8'h06;
  localparam logic [7:0] OP_SRAV  = 8'h07;
  localparam logic [7:0] OP_SLL   = 8'h7c;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_ADDIU = 8'h56;
  localparam logic [7:0] OP_LW    = 8'he3;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_ARITH = 3'b100;
  localparam logic [2:0] RES_LDST  = 3'b111;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sa;

  assign op = inst_i[31:26];
  assign rs = inst_i[25:21];
  assign rt = inst_i[20:16];
  assign rd = inst_i[15:11];
  assign sa = inst_i[10:6];
  assign fn = inst_i[5:0];

  logic is_r, is_s, is_logi, is_lui, is_addiu, is_lw;

  assign is_r = (op == 6'h00) && (sa == 5'd0) &&
    (fn inside {6'h24, 6'h25, 6'h26, 6'h27,
                6'h04, 6'h06, 6'h07, 6'h21, 6'h23});
  // The all-zero NOP word lands here as SLL $0,$0,0.
  assign is_s = (op == 6'h00) && (rs == 5'd0) &&
    (fn inside {6'h00, 6'h02, 6'h03});
  assign is_logi  = op inside {6'h0c, 6'h0d, 6'h0e};
  assign is_lui   = (op == 6'h0f);
  assign is_addiu = (op == 6'h09);
  assign is_lw    = (op == 6'h23);

  logic [7:0]        aluop_d;
  logic [2:0]        alusel_d;
  logic              re1, re2;
  logic [4:0]        wd_d;
  logic              wreg_d;
  logic              inv_d;
  logic [DATA_W-1:0] imm;

  always_comb begin
    aluop_d  = OP_NOP;
    alusel_d = RES_NOP;
    re1      = 1'b0;
    re2      = 1'b0;
    wd_d     = 5'd0;
    wreg_d   = 1'b0;
    inv_d    = 1'b1;
    imm      = '0;
    unique case (1'b1)
      is_r: begin
        re1    = 1'b1;
        re2    = 1'b1;
        wd_d   = rd;
        wreg_d = 1'b1;
        inv_d  = 1'b0;
        case (fn)
          6'h24: begin aluop_d = OP_AND;  alusel_d = RES_LOGIC; end
          6'h25: begin aluop_d = OP_OR;   alusel_d = RES_LOGIC; end
          6'h26: begin aluop_d = OP_XOR;  alusel_d = RES_LOGIC; end
          6'h27: begin aluop_d = OP_NOR;  alusel_d = RES_LOGIC; end
          6'h04: begin aluop_d = OP_SLLV; alusel_d = RES_SHIFT; end
          6'h06: begin aluop_d = OP_SRLV; alusel_d = RES_SHIFT; end
          6'h07: begin aluop_d = OP_SRAV; alusel_d = RES_SHIFT; end
          6'h21: begin aluop_d = OP_ADDU; alusel_d = RES_ARITH; end
          6'h23: begin aluop_d = OP_SUBU; alusel_d = RES_ARITH; end
          default: ;
        endcase
      end
      is_s: begin
        re2      = 1'b1;
        imm      = DATA_W'(sa);
        wd_d     = rd;
        wreg_d   = 1'b1;
        inv_d    = 1'b0;
        alusel_d = RES_SHIFT;
        case (fn)
          6'h00:   aluop_d = OP_SLL;
          6'h02:   aluop_d = OP_SRL;
          default: aluop_d = OP_SRA;
        endcase
      end
      is_logi: begin
        re1      = 1'b1;
        imm      = DATA_W'(inst_i[15:0]);
        wd_d     = rt;
        wreg_d   = 1'b1;
        inv_d    = 1'b0;
        alusel_d = RES_LOGIC;
        case (op)
          6'h0c:   aluop_d = OP_AND;
          6'h0d:   aluop_d = OP_OR;
          default: aluop_d = OP_XOR;
        endcase
      end
      is_lui: begin
        imm      = DATA_W'({inst_i[15:0], 16'h0000});
        wd_d     = rt;
        wreg_d   = 1'b1;
        inv_d    = 1'b0;
        aluop_d  = OP_OR;
        alusel_d = RES_LOGIC;
      end
      is_addiu: begin
        re1      = 1'b1;
        imm      = DATA_W'($signed(inst_i[15:0]));
        wd_d     = rt;
        wreg_d   = 1'b1;
        inv_d    = 1'b0;
        aluop_d  = OP_ADDIU;
        alusel_d = RES_ARITH;
      end
      is_lw: begin
        re1      = 1'b1;
        imm      = DATA_W'($signed(inst_i[15:0]));
        wd_d     = rt;
        wreg_d   = 1'b1;
        inv_d    = 1'b0;
        aluop_d  = OP_LW;
        alusel_d = RES_LDST;
      end
      default: ;
    endcase
  end

  assign rf_re1_o    = re1;
  assign rf_re2_o    = re2;
  assign rf_raddr1_o = rs;
  assign rf_raddr2_o = rt;

  logic [DATA_W-1:0] reg1_d, reg2_d;

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    reg1_d = rf_rdata1_i;
    if (!re1) begin
      reg1_d = imm;
    end else if (rs == 5'd0) begin
      reg1_d = '0;
    end else begin
      for (int k = FWD_N - 1; k >= 0; k--) begin
        if (fwd_we_i[k] && fwd_wa_i[5*k +: 5] == rs)
          reg1_d = fwd_wd_i[DATA_W*k +: DATA_W];
      end
    end
  end

  always_comb begin
    reg2_d = rf_rdata2_i;
    if (!re2) begin
      reg2_d = imm;
    end else if (rt == 5'd0) begin
      reg2_d = '0;
    end else begin
      for (int k = FWD_N - 1; k >= 0; k--) begin
        if (fwd_we_i[k] && fwd_wa_i[5*k +: 5] == rt)
          reg2_d = fwd_wd_i[DATA_W*k +: DATA_W];
      end
    end
  end

  assign stall_req_o = ex_is_load_i && (ex_wd_i != 5'd0) &&
    ((re1 && rs == ex_wd_i) || (re2 && rt == ex_wd_i));

  logic [7:0]        aluop_q;
  logic [2:0]        alusel_q;
  logic [DATA_W-1:0] reg1_q, reg2_q;
  logic [4:0]        wd_q;
  logic              wreg_q, inv_q;
  logic [31:0]       inst_q, pc_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i || (id_stall_i && !ex_stall_i)) begin
      aluop_q  <= OP_NOP;
      alusel_q <= RES_NOP;
      reg1_q   <= '0;
      reg2_q   <= '0;
      wd_q     <= 5'd0;
      wreg_q   <= 1'b0;
      inv_q    <= 1'b0;
      inst_q   <= 32'd0;
      pc_q     <= 32'd0;
    end else if (!id_stall_i) begin
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      inv_q    <= inv_d;
      inst_q   <= inst_i;
      pc_q     <= pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (stall_req_o && cnt_q != {CNT_W{1'b1}})
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign ex_aluop_o   = aluop_q;
  assign ex_alusel_o  = alusel_q;
  assign ex_reg1_o    = reg1_q;
  assign ex_reg2_o    = reg2_q;
  assign ex_wd_o      = wd_q;
  assign ex_wreg_o    = wreg_q;
  assign ex_inst_o    = inst_q;
  assign ex_pc_o      = pc_q;
  assign ex_invalid_o = inv_q;
  assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed vector table, hand sequences
// for stall/hold/flush/saturation, and randomized model checking.
module tb_id_issue_stage;

  localparam int DW = 32;
  localparam int FN = 2;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [31:0]   pc, inst, rd1, rd2;
  logic          re1, re2;
  logic [4:0]    ra1, ra2;
  logic [1:0]    fwe;
  logic [4:0]    fwa [2];
  logic [31:0]   fdat [2];
  logic [9:0]    fwa_v;
  logic [63:0]   fwd_v;
  logic          ld;
  logic [4:0]    exwd;
  logic          ids, exs, flush;
  logic          stall_req;
  logic [7:0]    aluop;
  logic [2:0]    alusel;
  logic [31:0]   r1, r2, xinst, xpc;
  logic [4:0]    xwd;
  logic          xwreg, xinv;
  logic [CW-1:0] cnt;

  assign fwa_v = {fwa[1], fwa[0]};
  assign fwd_v = {fdat[1], fdat[0]};

  id_issue_stage #(.DATA_W(DW), .FWD_N(FN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .inst_i(inst),
    .rf_rdata1_i(rd1), .rf_rdata2_i(rd2),
    .rf_re1_o(re1), .rf_re2_o(re2),
    .rf_raddr1_o(ra1), .rf_raddr2_o(ra2),
    .fwd_we_i(fwe), .fwd_wa_i(fwa_v), .fwd_wd_i(fwd_v),
    .ex_is_load_i(ld), .ex_wd_i(exwd),
    .id_stall_i(ids), .ex_stall_i(exs), .flush_i(flush),
    .stall_req_o(stall_req),
    .ex_aluop_o(aluop), .ex_alusel_o(alusel),
    .ex_reg1_o(r1), .ex_reg2_o(r2), .ex_wd_o(xwd),
    .ex_wreg_o(xwreg), .ex_inst_o(xinst), .ex_pc_o(xpc),
    .ex_invalid_o(xinv), .stall_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  typedef struct packed {
    logic        inv;
    logic        wreg;
    logic [4:0]  wd;
    logic        use_rs;
    logic        use_rt;
    logic [31:0] imm;
  } dec_t;

  typedef struct packed {
    logic [31:0] r1, r2, inst, pc;
    logic [4:0]  wd;
    logic        wreg, inv, nop;
  } ex_t;

  ex_t exp_q;
  int  cnt_m;

  function automatic dec_t mdec(logic [31:0] w);
    dec_t d;
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    d = '0;
    d.inv = 1'b1;
    if (op == 0 && w[10:6] == 0 && fn inside
        {6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23}) begin
      d = '{inv: 0, wreg: 1, wd: w[15:11], use_rs: 1, use_rt: 1, imm: 0};
    end else if (op == 0 && w[25:21] == 0 && fn inside {6'h00, 6'h02, 6'h03}) begin
      d = '{inv: 0, wreg: 1, wd: w[15:11], use_rs: 0, use_rt: 1,
            imm: {27'd0, w[10:6]}};
    end else if (op inside {6'h0c, 6'h0d, 6'h0e}) begin
      d = '{inv: 0, wreg: 1, wd: w[20:16], use_rs: 1, use_rt: 0,
            imm: {16'd0, w[15:0]}};
    end else if (op inside {6'h09, 6'h23}) begin
      d = '{inv: 0, wreg: 1, wd: w[20:16], use_rs: 1, use_rt: 0,
            imm: {{16{w[15]}}, w[15:0]}};
    end else if (op == 6'h0f) begin
      d = '{inv: 0, wreg: 1, wd: w[20:16], use_rs: 0, use_rt: 0,
            imm: {w[15:0], 16'd0}};
    end
    return d;
  endfunction

  function automatic logic [31:0] mval(logic [4:0] a, logic [31:0] rf);
    if (a == 0) return 32'd0;
    for (int k = 0; k < FN; k++)
      if (fwe[k] && fwa[k] == a) return fdat[k];
    return rf;
  endfunction

  task automatic check_ex(string t);
    if (!exp_q.inv) begin
      chk({t, "_reg1"}, r1, exp_q.r1);
      chk({t, "_reg2"}, r2, exp_q.r2);
      chk({t, "_wd"}, {27'd0, xwd}, {27'd0, exp_q.wd});
    end
    chk({t, "_wreg"}, {31'd0, xwreg}, {31'd0, exp_q.wreg});
    chk({t, "_inv"}, {31'd0, xinv}, {31'd0, exp_q.inv});
    chk({t, "_inst"}, xinst, exp_q.inst);
    chk({t, "_pc"}, xpc, exp_q.pc);
    chk({t, "_cnt"}, {28'd0, cnt}, cnt_m);
    if (exp_q.nop) begin
      chk({t, "_aluop"}, {24'd0, aluop}, 32'd0);
      chk({t, "_alusel"}, {29'd0, alusel}, 32'd0);
    end else begin
      chk({t, "_aluop_nz"}, {31'd0, aluop != 8'd0}, 32'd1);
    end
  endtask

  task automatic step(string t);
    dec_t d;
    ex_t  nx;
    logic st;
    d  = mdec(inst);
    st = ld && exwd != 0 &&
         ((d.use_rs && inst[25:21] == exwd) ||
          (d.use_rt && inst[20:16] == exwd));
    #1;
    chk({t, "_stall"}, {31'd0, stall_req}, {31'd0, st});
    chk({t, "_re1"}, {31'd0, re1}, {31'd0, d.use_rs});
    chk({t, "_re2"}, {31'd0, re2}, {31'd0, d.use_rt});
    if (rst || flush || (ids && !exs)) begin
      nx = '0;
      nx.nop = 1'b1;
    end else if (ids) begin
      nx = exp_q;
    end else begin
      nx.r1   = d.use_rs ? mval(inst[25:21], rd1) : d.imm;
      nx.r2   = d.use_rt ? mval(inst[20:16], rd2) : d.imm;
      nx.wd   = d.wd;
      nx.wreg = d.wreg;
      nx.inv  = d.inv;
      nx.nop  = d.inv;
      nx.inst = inst;
      nx.pc   = pc;
    end
    if (rst) cnt_m = 0;
    else if (st && cnt_m < (1 << CW) - 1) cnt_m++;
    exp_q = nx;
    @(posedge clk);
    #1;
    check_ex(t);
  endtask

  function automatic logic [31:0] rt_(logic [5:0] f, logic [4:0] s,
      logic [4:0] t, logic [4:0] d, logic [4:0] a);
    return {6'h00, s, t, d, a, f};
  endfunction

  function automatic logic [31:0] it_(logic [5:0] o, logic [4:0] s,
      logic [4:0] t, logic [15:0] i);
    return {o, s, t, i};
  endfunction

  typedef struct {
    logic [31:0] inst, rd1, rd2;
    logic [1:0]  fwe;
    logic [4:0]  fa0, fa1;
    logic [31:0] fd0, fd1;
    logic        ld;
    logic [4:0]  exwd;
    logic [31:0] e1, e2;
    logic [4:0]  ewd;
    logic        ewreg, einv, estall;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  function automatic logic [31:0] rinst();
    logic [5:0] rfn [9] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h04,
                            6'h06, 6'h07, 6'h21, 6'h23};
    logic [5:0] sfn [3] = '{6'h00, 6'h02, 6'h03};
    logic [5:0] iop [6] = '{6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h09, 6'h23};
    logic [4:0] s = 5'($urandom_range(0, 7));
    logic [4:0] t = 5'($urandom_range(0, 7));
    logic [4:0] d = 5'($urandom_range(0, 7));
    logic [4:0] a;
    case ($urandom_range(0, 3))
      0: begin
        a = ($urandom_range(0, 7) == 0) ? 5'd1 : 5'd0;
        return rt_(rfn[$urandom_range(0, 8)], s, t, d, a);
      end
      1: begin
        if ($urandom_range(0, 5) != 0) s = 5'd0;
        return rt_(sfn[$urandom_range(0, 2)], s, t, d,
                   5'($urandom_range(0, 31)));
      end
      2: return it_(iop[$urandom_range(0, 5)], s, t,
                    16'($urandom));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] held;

  initial begin
    vt[0]  = '{it_(6'h0d, 0, 1, 16'h1100), 32'hdeadbeef, 0, 2'b00, 0, 0, 0, 0,
               0, 0, 32'h0, 32'h1100, 1, 1, 0, 0};
    vt[1]  = '{it_(6'h0d, 1, 2, 16'h0022), 32'h55555555, 0, 2'b01, 1, 0,
               32'h1100, 0, 0, 0, 32'h1100, 32'h22, 2, 1, 0, 0};
    vt[2]  = '{rt_(6'h21, 3, 3, 4, 0), 32'h1111, 32'h2222, 2'b11, 3, 3,
               32'haaaa, 32'hbbbb, 0, 0, 32'haaaa, 32'haaaa, 4, 1, 0, 0};
    vt[3]  = '{rt_(6'h21, 3, 3, 4, 0), 32'h1111, 32'h2222, 2'b10, 3, 3,
               32'haaaa, 32'hbbbb, 0, 0, 32'hbbbb, 32'hbbbb, 4, 1, 0, 0};
    vt[4]  = '{rt_(6'h25, 0, 0, 5, 0), 32'h1234, 32'h1234, 2'b01, 0, 0,
               32'hffff, 0, 0, 0, 32'h0, 32'h0, 5, 1, 0, 0};
    vt[5]  = '{it_(6'h09, 0, 2, 16'h8000), 32'h77, 0, 2'b00, 0, 0, 0, 0,
               0, 0, 32'h0, 32'hffff8000, 2, 1, 0, 0};
    vt[6]  = '{it_(6'h0f, 0, 2, 16'h1234), 32'h99, 0, 2'b00, 0, 0, 0, 0,
               0, 0, 32'h12340000, 32'h12340000, 2, 1, 0, 0};
    vt[7]  = '{{6'h3f, 26'h0123456}, 1, 2, 2'b00, 0, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 1, 0};
    vt[8]  = '{rt_(6'h04, 9, 7, 8, 0), 32'h99, 32'h77, 2'b00, 0, 0, 0, 0,
               1, 7, 32'h99, 32'h77, 8, 1, 0, 1};
    vt[9]  = '{rt_(6'h04, 9, 7, 8, 0), 32'h99, 32'h77, 2'b00, 0, 0, 0, 0,
               1, 0, 32'h99, 32'h77, 8, 1, 0, 0};
    vt[10] = '{rt_(6'h03, 0, 11, 10, 5), 32'h1, 32'hcafe, 2'b00, 0, 0, 0, 0,
               0, 0, 32'h5, 32'hcafe, 10, 1, 0, 0};
    vt[11] = '{it_(6'h0c, 4, 3, 16'hf00f), 32'h1, 0, 2'b00, 0, 0, 0, 0,
               1, 4, 32'h1, 32'hf00f, 3, 1, 0, 1};
    vt[12] = '{it_(6'h23, 5, 6, 16'hfffc), 32'h1000, 32'h5, 2'b00, 0, 0, 0, 0,
               1, 6, 32'h1000, 32'hfffffffc, 6, 1, 0, 0};
    vt[13] = '{rt_(6'h24, 1, 2, 3, 1), 1, 2, 2'b00, 0, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 1, 0};
    vt[14] = '{rt_(6'h00, 1, 2, 3, 4), 1, 2, 2'b00, 0, 0, 0, 0,
               1, 2, 0, 0, 0, 0, 1, 0};
    vt[15] = '{rt_(6'h26, 2, 3, 1, 0), 1, 2, 2'b11, 2, 3, 32'hd0, 32'hd1,
               0, 0, 32'hd0, 32'hd1, 1, 1, 0, 0};
    vt[16] = '{rt_(6'h21, 6, 7, 12, 0), 32'h66, 32'h67, 2'b00, 6, 7,
               32'hee, 32'hef, 0, 0, 32'h66, 32'h67, 12, 1, 0, 0};

    rst = 1; pc = 0; inst = 0; rd1 = 0; rd2 = 0; fwe = 0;
    fwa[0] = 0; fwa[1] = 0; fdat[0] = 0; fdat[1] = 0;
    ld = 0; exwd = 0; ids = 0; exs = 0; flush = 0;
    exp_q = '0; exp_q.nop = 1; cnt_m = 0;
    step("rst0");
    step("rst1");
    rst = 0;

    for (int i = 0; i < NV; i++) begin
      inst = vt[i].inst; rd1 = vt[i].rd1; rd2 = vt[i].rd2;
      fwe = vt[i].fwe; fwa[0] = vt[i].fa0; fwa[1] = vt[i].fa1;
      fdat[0] = vt[i].fd0; fdat[1] = vt[i].fd1;
      ld = vt[i].ld; exwd = vt[i].exwd;
      pc = 32'h400 + 32'(i * 4);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall_req},
          {31'd0, vt[i].estall});
      @(posedge clk);
      #1;
      if (!vt[i].einv) begin
        chk($sformatf("v%0d_reg1", i), r1, vt[i].e1);
        chk($sformatf("v%0d_reg2", i), r2, vt[i].e2);
        chk($sformatf("v%0d_wd", i), {27'd0, xwd}, {27'd0, vt[i].ewd});
      end
      chk($sformatf("v%0d_wreg", i), {31'd0, xwreg}, {31'd0, vt[i].ewreg});
      chk($sformatf("v%0d_inv", i), {31'd0, xinv}, {31'd0, vt[i].einv});
      chk($sformatf("v%0d_pc", i), xpc, 32'h400 + 32'(i * 4));
      if (vt[i].einv) chk($sformatf("v%0d_aluop", i), {24'd0, aluop}, 0);
    end

    fwe = 0; ld = 0; exwd = 0;
    rst = 1; step("rst2");
    rst = 0;

    inst = rt_(6'h21, 1, 2, 3, 0); pc = 32'h100;
    step("lu_pre");
    inst = rt_(6'h04, 9, 7, 8, 0); pc = 32'h104;
    ld = 1; exwd = 7; ids = 1; exs = 0;
    step("lu");
    chk("lu_wreg", {31'd0, xwreg}, 0);
    chk("lu_aluop", {24'd0, aluop}, 0);
    chk("lu_cnt", {28'd0, cnt}, 1);
    ld = 0; ids = 0;

    held = it_(6'h0d, 0, 4, 16'h00ab);
    inst = held; pc = 32'h200;
    step("hold_pre");
    inst = rt_(6'h21, 1, 2, 3, 0); pc = 32'h204;
    ids = 1; exs = 1;
    step("hold0");
    step("hold1");
    chk("hold_inst", xinst, held);
    chk("hold_reg2", r2, 32'hab);
    ids = 0; exs = 1;
    step("exs_only");

    exs = 0; rst = 1; step("rst3");
    rst = 0;
    inst = rt_(6'h04, 9, 7, 8, 0); ld = 1; exwd = 7;
    for (int i = 0; i < (1 << CW) + 3; i++) step("sat");
    chk("sat_cnt", {28'd0, cnt}, 15);
    ld = 0; flush = 1;
    inst = rt_(6'h21, 1, 2, 3, 0);
    step("flush");
    chk("flush_wreg", {31'd0, xwreg}, 0);
    chk("flush_cnt", {28'd0, cnt}, 15);
    flush = 0; rst = 1; ld = 1;
    inst = rt_(6'h04, 9, 7, 8, 0);
    step("rst_cnt");
    chk("rst_cnt0", {28'd0, cnt}, 0);
    rst = 0; ld = 0;

    for (int i = 0; i < 400; i++) begin
      inst = rinst(); pc = $urandom; rd1 = $urandom; rd2 = $urandom;
      fwe = 2'($urandom_range(0, 3));
      fwa[0] = 5'($urandom_range(0, 7)); fwa[1] = 5'($urandom_range(0, 7));
      fdat[0] = $urandom; fdat[1] = $urandom;
      ld = 1'($urandom_range(0, 1)); exwd = 5'($urandom_range(0, 7));
      ids = ($urandom_range(0, 4) == 0);
      exs = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 29) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
